// File: rtl/axis_packet_source.sv
// Command-driven AXI-stream packet source: one {length, seed} command becomes a
// packet of `length` incrementing beats, TLAST on the final beat, then an optional idle gap.
module axis_packet_source #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       pkt_count,
  output logic              err_zero_len
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  logic [1:0]        state_q,     state_d;
  logic              m_valid_q,   m_valid_d;
  logic [DATA_W-1:0] m_data_q,    m_data_d;
  logic              m_last_q,    m_last_d;
  logic [LEN_W-1:0]  rem_q,       rem_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              err_q,       err_d;
  logic [7:0]        gap_cnt_q,   gap_cnt_d;

  logic cmd_fire_s;
  logic beat_fire_s;

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign cmd_fire_s   = cmd_valid & cmd_ready;
  assign beat_fire_s  = m_valid_q & m_ready;

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign pkt_count    = pkt_count_q;
  assign err_zero_len = err_q;

  // Next-state logic: every output register changes only on a handshake or state step
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    rem_d       = rem_q;
    pkt_count_d = pkt_count_q;
    err_d       = 1'b0;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire_s) begin
          if (cmd_len == {LEN_W{1'b0}}) begin
            err_d = 1'b1;
          end else begin
            state_d   = SEND;
            m_valid_d = 1'b1;
            m_data_d  = cmd_seed;
            m_last_d  = (cmd_len == LEN_W'(1));
            rem_d     = cmd_len;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (beat_fire_s) begin
          if (rem_q == LEN_W'(1)) begin
            m_valid_d   = 1'b0;
            m_last_d    = 1'b0;
            pkt_count_d = pkt_count_q + 16'd1;
            rem_d       = {LEN_W{1'b0}};
            if (GAP_LOAD != 8'd0) begin
              state_d   = GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d   = IDLE;
            end
          end else begin
            m_data_d = m_data_q + DATA_W'(1);
            rem_d    = rem_q - LEN_W'(1);
            m_last_d = (rem_q == LEN_W'(2));
          end
        end else begin
          state_d = SEND;
        end
      end

      GAP: begin
        // Counter was loaded with the full gap, so leaving at 1 gives exactly GAP_CYCLES cycles
        if (gap_cnt_q <= 8'd1) begin
          state_d   = IDLE;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_valid_q   <= 1'b0;
      m_data_q    <= {DATA_W{1'b0}};
      m_last_q    <= 1'b0;
      rem_q       <= {LEN_W{1'b0}};
      pkt_count_q <= 16'd0;
      err_q       <= 1'b0;
      gap_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      rem_q       <= rem_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_packet_source.sv
// Directed bench for axis_packet_source: one instance with no gap, one with a two-cycle gap.
module tb_axis_packet_source;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        cmd_valid, cmd_ready, m_valid, m_ready, m_last, busy, err_zero_len;
  logic [15:0] cmd_len, pkt_count;
  logic [31:0] cmd_seed, m_data;

  logic        g_cmd_valid, g_cmd_ready, g_m_valid, g_m_ready, g_m_last, g_busy, g_err;
  logic [15:0] g_cmd_len, g_pkt_count;
  logic [31:0] g_cmd_seed, g_m_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_packet_source #(.DATA_W(32), .LEN_W(16), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .pkt_count(pkt_count), .err_zero_len(err_zero_len)
  );

  axis_packet_source #(.DATA_W(32), .LEN_W(16), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready), .cmd_len(g_cmd_len), .cmd_seed(g_cmd_seed),
    .m_valid(g_m_valid), .m_ready(g_m_ready), .m_data(g_m_data), .m_last(g_m_last),
    .busy(g_busy), .pkt_count(g_pkt_count), .err_zero_len(g_err)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_len = 16'd0; cmd_seed = 32'd0; m_ready = 1'b0;
    g_cmd_valid = 1'b0; g_cmd_len = 16'd0; g_cmd_seed = 32'd0; g_m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_valid, m_last, busy, err_zero_len, cmd_ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_flags got %b want 00001", {m_valid, m_last, busy, err_zero_len, cmd_ready});
    end
    checks++;
    if (m_data !== 32'd0 || pkt_count !== 16'd0) begin
      errors++; $display("FAIL reset_values got data=%h cnt=%0d want 0/0", m_data, pkt_count);
    end
    checks++;
    if (g_cmd_ready !== 1'b1 || g_busy !== 1'b0) begin
      errors++; $display("FAIL reset_gapdut got ready=%b busy=%b want 1/0", g_cmd_ready, g_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cmd_valid = 1'b1; cmd_len = 16'd4; cmd_seed = 32'h10; m_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy got ready=%b busy=%b want 0/1", cmd_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'h10 + 32'(i) || m_last !== (i == 3)) begin
        errors++; $display("FAIL basic_beat%0d got v=%b d=%h l=%b want 1/%h/%b",
                           i, m_valid, m_data, m_last, 32'h10 + 32'(i), (i == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || pkt_count !== 16'd1) begin
      errors++; $display("FAIL basic_end got v=%b l=%b cnt=%0d want 0/0/1", m_valid, m_last, pkt_count);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle got ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int b;
    pat = 6'b110010;  // bit c is m_ready in stall cycle c: 0,1,0,0,1,1
    b = 0;
    cmd_valid = 1'b1; cmd_len = 16'd3; cmd_seed = 32'd0; m_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'(b) || m_last !== (b == 2)) begin
        errors++; $display("FAIL stall_cyc%0d got v=%b d=%h l=%b want 1/%h/%b",
                           c, m_valid, m_data, m_last, 32'(b), (b == 2));
      end
      m_ready = pat[c];
      @(negedge clk);
      if (pat[c]) b++;
    end
    checks++;
    if (m_valid !== 1'b0 || pkt_count !== 16'd2) begin
      errors++; $display("FAIL stall_end got v=%b cnt=%0d want 0/2", m_valid, pkt_count);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_wrap();
    cmd_valid = 1'b1; cmd_len = 16'd2; cmd_seed = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hFFFF_FFFF || m_last !== 1'b0) begin
      errors++; $display("FAIL wrap_b0 got v=%b d=%h l=%b want 1/ffffffff/0", m_valid, m_data, m_last);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h0 || m_last !== 1'b1) begin
      errors++; $display("FAIL wrap_b1 got v=%b d=%h l=%b want 1/00000000/1", m_valid, m_data, m_last);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 16'd1; cmd_seed = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hFFFF_FFFF || m_last !== 1'b1) begin
      errors++; $display("FAIL single_beat got v=%b d=%h l=%b want 1/ffffffff/1", m_valid, m_data, m_last);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || pkt_count !== 16'd4) begin
      errors++; $display("FAIL single_end got v=%b cnt=%0d want 0/4", m_valid, pkt_count);
    end
  endtask

  task automatic test_zero_len();
    cmd_valid = 1'b1; cmd_len = 16'd0; cmd_seed = 32'h1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (err_zero_len !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL zero_pulse got err=%b v=%b busy=%b rdy=%b want 1/0/0/1",
                         err_zero_len, m_valid, busy, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (err_zero_len !== 1'b0 || m_valid !== 1'b0 || pkt_count !== 16'd4) begin
      errors++; $display("FAIL zero_after got err=%b v=%b cnt=%0d want 0/0/4", err_zero_len, m_valid, pkt_count);
    end
  endtask

  task automatic test_back_to_back_gap();
    g_m_ready = 1'b1;
    g_cmd_valid = 1'b1; g_cmd_len = 16'd2; g_cmd_seed = 32'h100;
    @(negedge clk);
    g_cmd_len = 16'd1; g_cmd_seed = 32'h200;
    checks++;
    if (g_m_valid !== 1'b1 || g_m_data !== 32'h100 || g_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL gap_b0 got v=%b d=%h rdy=%b want 1/100/0", g_m_valid, g_m_data, g_cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (g_m_data !== 32'h101 || g_m_last !== 1'b1) begin
      errors++; $display("FAIL gap_b1 got d=%h l=%b want 101/1", g_m_data, g_m_last);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (g_cmd_ready !== 1'b0 || g_busy !== 1'b1 || g_m_valid !== 1'b0) begin
        errors++; $display("FAIL gap_cyc%0d got rdy=%b busy=%b v=%b want 0/1/0", c, g_cmd_ready, g_busy, g_m_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (g_cmd_ready !== 1'b1 || g_m_valid !== 1'b0 || g_pkt_count !== 16'd1) begin
      errors++; $display("FAIL gap_reidle got rdy=%b v=%b cnt=%0d want 1/0/1", g_cmd_ready, g_m_valid, g_pkt_count);
    end
    @(negedge clk);
    g_cmd_valid = 1'b0;
    checks++;
    if (g_m_valid !== 1'b1 || g_m_data !== 32'h200 || g_m_last !== 1'b1) begin
      errors++; $display("FAIL gap_pkt2 got v=%b d=%h l=%b want 1/200/1", g_m_valid, g_m_data, g_m_last);
    end
    @(negedge clk);
    checks++;
    if (g_m_valid !== 1'b0 || g_cmd_ready !== 1'b0 || g_pkt_count !== 16'd2) begin
      errors++; $display("FAIL gap_pkt2_end got v=%b rdy=%b cnt=%0d want 0/0/2", g_m_valid, g_cmd_ready, g_pkt_count);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    cmd_valid = 1'b1; cmd_len = 16'd5; cmd_seed = 32'h40; m_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h42) begin
      errors++; $display("FAIL mid_pre got v=%b d=%h want 1/42", m_valid, m_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || pkt_count !== 16'd0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b busy=%b want 0/0/1/0",
                         m_valid, pkt_count, cmd_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 16'd1; cmd_seed = 32'h55;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h55 || m_last !== 1'b1) begin
      errors++; $display("FAIL post_reset_beat got v=%b d=%h l=%b want 1/55/1", m_valid, m_data, m_last);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || pkt_count !== 16'd1) begin
      errors++; $display("FAIL post_reset_cnt got v=%b cnt=%0d want 0/1", m_valid, pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_back_to_back_gap();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
